pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-004 id_branch, id_jr, id_jump  in  1 each  ID holds a conditional branch / jr or jalr / any jump.
REQ-005 id_taken  in  1  branch condition true in ID, using forwarded operands.
REQ-006 ex_rs, ex_rt  in  5 each  source registers of the instruction in EX.
REQ-007 ex_regwr, ex_memrd  in  1 each; ex_wrreg  in  5  EX-stage destination info.
REQ-008 mem_regwr, mem_memrd  in  1 each; mem_wrreg  in  5  MEM-stage destination info.
REQ-009 wb_regwr  in  1; wb_wrreg  in  5  WB-stage destination info.
REQ-010 irq  in  1  level interrupt request.
REQ-011 pc_write, ifid_write  out  1 each  enable PC and IF/ID register updates.
REQ-012 ifid_flush, idex_flush  out  1 each  insert a bubble into IF/ID or ID/EX.
REQ-013 forward_c, forward_d  out  1 each  select the MEM-stage ALU result for ID operand A/B.
REQ-014 forward_a, forward_b  out  2 each  EX operand select: 00 regfile, 10 MEM, 01 WB.
REQ-015 irq_take  out  1  one-cycle pulse telling the control unit to enter the interrupt handler.

Function
REQ-016 Register 0 SHALL never match for forwarding or hazard detection.
REQ-017 forward_c SHALL be 1 when mem_regwr=1, mem_memrd=0 and mem_wrreg equals id_rs; forward_d uses id_rt under the same rule.
REQ-018 forward_a SHALL be 10 on a MEM match with ex_rs, else 01 on a WB match, else 00; MEM has priority. forward_b uses ex_rt under the same rule.
REQ-019 Load-use: ex_memrd=1 and ex_wrreg in {id_rs,id_rt} SHALL request 1 stall cycle.
REQ-020 Branch or jr in ID depending on a non-load EX write SHALL request 1 stall; depending on an EX load SHALL request 2 stalls; depending on a MEM load SHALL request 1 stall.
REQ-021 FSM states: RUN, STALL2, STALL1. RUN->STALL2 on a 2-stall request; RUN->STALL1 on a 1-stall request; STALL2->STALL1; STALL1->RUN.
REQ-022 The entering cycle and each stall cycle SHALL drive pc_write=0, ifid_write=0, idex_flush=1; otherwise pc_write=1, ifid_write=1, idex_flush=0.
REQ-023 In a non-stall cycle with (id_branch & id_taken) or id_jump, ifid_flush SHALL be 1 for exactly that cycle.
REQ-024 When a stall request and id_taken occur together, the stall SHALL win and ifid_flush SHALL be 0.
REQ-025 irq SHALL set irq_pending on its rising edge; pending is held through stalls.
REQ-026 irq_take SHALL pulse for one cycle in RUN with no stall request and no ifid_flush; that pulse clears irq_pending.
REQ-027 A new irq edge during the irq_take cycle SHALL keep irq_pending set.
REQ-028 Stall requests SHALL be evaluated only in RUN; inputs seen during STALL2 or STALL1 do not extend the sequence.

Reset
REQ-029 On reset=1 at a clock edge: state=RUN, irq_pending=0, stored irq level=0.
REQ-030 While reset=1: pc_write=1, ifid_write=1, both flushes=0, all forwards=0, irq_take=0.
REQ-031 Reset asserted in STALL2 or STALL1 SHALL return to RUN on the next edge with no residual stall.

Structure
REQ-032 The shared package SHALL hold the state encoding (RUN, STALL2, STALL1) and the forward-select constants (FWD_RF=00, FWD_MEM=10, FWD_WB=01).
REQ-033 EX forwarding SHALL be a combinational sub-module pipeline_fwd_unit, instantiated once.

Verification
REQ-034 ex_memrd=1, ex_wrreg=5, id_rs=5 -> exactly 1 cycle of pc_write=0 and idex_flush=1, then RUN.
REQ-035 id_branch=1, ex_memrd=1, ex_regwr=1, ex_wrreg=8, id_rt=8 -> 2 stall cycles (STALL2, STALL1); forward_d=1 is not used for a load.
REQ-036 mem_regwr=1, mem_wrreg=3, wb_regwr=1, wb_wrreg=3, ex_rs=3 -> forward_a=10; mem_wrreg=0 with wb_wrreg=3 -> forward_a=01.
REQ-037 id_jump=1 with no hazard -> ifid_flush=1 for exactly one cycle; load-use with id_taken=1 in the same cycle -> ifid_flush=0.
REQ-038 irq rises during STALL1 -> irq_take=1 in the first clean RUN cycle, once; reset in STALL2 -> RUN next cycle with irq_pending=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e       : stall sequencer states (RUN, STALL2, STALL1)
//   FWD_*         : EX operand forward-select encodings
//   reg_match()   : destination/source compare that never matches register 0
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StStall2 = 2'd1,
        StStall1 = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    function automatic logic reg_match(input logic en, input logic [4:0] dst,
                                       input logic [4:0] src);
        return en && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_fwd_unit.sv
// EX-stage operand forwarding select (purely combinational).
//   ex_rs, ex_rt         : source registers of the instruction in EX
//   mem_regwr, mem_wrreg : MEM-stage destination
//   wb_regwr, wb_wrreg   : WB-stage destination
//   forward_a/forward_b  : FWD_MEM, else FWD_WB, else FWD_RF (MEM is the newer value)
module pipeline_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       mem_regwr,
    input  logic [4:0] mem_wrreg,
    input  logic       wb_regwr,
    input  logic [4:0] wb_wrreg,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (reg_match(mem_regwr, mem_wrreg, ex_rs)) begin
            forward_a = FWD_MEM;
        end else if (reg_match(wb_regwr, wb_wrreg, ex_rs)) begin
            forward_a = FWD_WB;
        end
        if (reg_match(mem_regwr, mem_wrreg, ex_rt)) begin
            forward_b = FWD_MEM;
        end else if (reg_match(wb_regwr, wb_wrreg, ex_rt)) begin
            forward_b = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding selects and interrupt entry.
//   clk, reset                 : clock, synchronous active-high reset
//   id_* / ex_* / mem_* / wb_* : per-stage register and control info
//   irq                        : level interrupt request (edge captured into irq_pending)
//   pc_write, ifid_write       : PC / IF-ID update enables (0 while stalling)
//   ifid_flush, idex_flush     : bubble insertion into IF/ID, ID/EX
//   forward_c/d                : MEM ALU result to ID operand A/B (branch compare)
//   forward_a/b                : EX operand select
//   irq_take                   : one-cycle interrupt entry pulse
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_branch,
    input  logic       id_jr,
    input  logic       id_jump,
    input  logic       id_taken,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       ex_regwr,
    input  logic       ex_memrd,
    input  logic [4:0] ex_wrreg,
    input  logic       mem_regwr,
    input  logic       mem_memrd,
    input  logic [4:0] mem_wrreg,
    input  logic       wb_regwr,
    input  logic [4:0] wb_wrreg,
    input  logic       irq,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       forward_c,
    output logic       forward_d,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b,
    output logic       irq_take
);

    state_e state_q, state_d;
    logic   irq_q, irq_pending_q, irq_pending_d;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    logic ex_ld_rs, ex_ld_rt, ex_alu_rs, ex_alu_rt, mem_ld_rs, mem_ld_rt;
    logic dep_ex_ld, dep_ex_alu, dep_mem_ld, load_use;
    logic req2, req1, stall_cycle, redirect;

    pipeline_fwd_unit u_fwd (
        .ex_rs     (ex_rs),
        .ex_rt     (ex_rt),
        .mem_regwr (mem_regwr),
        .mem_wrreg (mem_wrreg),
        .wb_regwr  (wb_regwr),
        .wb_wrreg  (wb_wrreg),
        .forward_a (fwd_a_raw),
        .forward_b (fwd_b_raw)
    );

    always_comb begin
        ex_ld_rs  = reg_match(ex_memrd, ex_wrreg, id_rs);
        ex_ld_rt  = reg_match(ex_memrd, ex_wrreg, id_rt);
        ex_alu_rs = reg_match(ex_regwr & ~ex_memrd, ex_wrreg, id_rs);
        ex_alu_rt = reg_match(ex_regwr & ~ex_memrd, ex_wrreg, id_rt);
        mem_ld_rs = reg_match(mem_memrd, mem_wrreg, id_rs);
        mem_ld_rt = reg_match(mem_memrd, mem_wrreg, id_rt);

        // A branch compares rs and rt in ID; jr/jalr only reads rs.
        dep_ex_ld  = (id_branch & (ex_ld_rs | ex_ld_rt)) | (id_jr & ex_ld_rs);
        dep_ex_alu = (id_branch & (ex_alu_rs | ex_alu_rt)) | (id_jr & ex_alu_rs);
        dep_mem_ld = (id_branch & (mem_ld_rs | mem_ld_rt)) | (id_jr & mem_ld_rs);
        load_use   = ex_ld_rs | ex_ld_rt;

        req2 = dep_ex_ld;
        req1 = load_use | dep_ex_alu | dep_mem_ld;

        // The requesting RUN cycle is the first bubble; STALL2 adds the second.
        // STALL1 is the release cycle: the held instruction proceeds without
        // its hazards being re-evaluated.
        stall_cycle = ((state_q == StRun) && (req1 || req2)) || (state_q == StStall2);
        redirect    = (id_branch & id_taken) | id_jump;
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        forward_c     = 1'b0;
        forward_d     = 1'b0;
        forward_a     = FWD_RF;
        forward_b     = FWD_RF;
        irq_take      = 1'b0;

        unique case (state_q)
            StRun: begin
                if (req2) begin
                    state_d = StStall2;
                end else if (req1) begin
                    state_d = StStall1;
                end
            end
            StStall2: state_d = StStall1;
            StStall1: state_d = StRun;
            default:  state_d = StRun;
        endcase

        if (!reset) begin
            forward_a = fwd_a_raw;
            forward_b = fwd_b_raw;
            forward_c = reg_match(mem_regwr & ~mem_memrd, mem_wrreg, id_rs);
            forward_d = reg_match(mem_regwr & ~mem_memrd, mem_wrreg, id_rt);
            if (stall_cycle) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end else begin
                ifid_flush = redirect;
            end
            irq_take = (state_q == StRun) && !stall_cycle && !ifid_flush && irq_pending_q;
        end

        // A fresh edge in the take cycle re-arms pending.
        irq_pending_d = (irq & ~irq_q) | (irq_pending_q & ~irq_take);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            irq_q         <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_q         <= irq;
            irq_pending_q <= irq_pending_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wrreg, mem_wrreg, wb_wrreg;
    logic       id_branch, id_jr, id_jump, id_taken;
    logic       ex_regwr, ex_memrd, mem_regwr, mem_memrd, wb_regwr, irq;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, forward_c, forward_d, irq_take;
    logic [1:0] forward_a, forward_b;

    int total = 0;
    int bad   = 0;
    logic [10:0] sb[$];
    logic [10:0] got, exp_v;

    // {pc_write, ifid_write, ifid_flush, idex_flush, fc, fd, fa, fb, irq_take}
    localparam logic [10:0] RUNV   = 11'b11000000000;
    localparam logic [10:0] STALLV = 11'b00010000000;
    localparam logic [10:0] JUMPV  = 11'b11100000000;
    localparam logic [10:0] TAKEV  = 11'b11000000001;

    assign got = {pc_write, ifid_write, ifid_flush, idex_flush, forward_c, forward_d,
                  forward_a, forward_b, irq_take};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_branch  (id_branch),
        .id_jr      (id_jr),
        .id_jump    (id_jump),
        .id_taken   (id_taken),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_regwr   (ex_regwr),
        .ex_memrd   (ex_memrd),
        .ex_wrreg   (ex_wrreg),
        .mem_regwr  (mem_regwr),
        .mem_memrd  (mem_memrd),
        .mem_wrreg  (mem_wrreg),
        .wb_regwr   (wb_regwr),
        .wb_wrreg   (wb_wrreg),
        .irq        (irq),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .forward_c  (forward_c),
        .forward_d  (forward_d),
        .forward_a  (forward_a),
        .forward_b  (forward_b),
        .irq_take   (irq_take)
    );

    function automatic logic [10:0] fwd(input logic fc, input logic fd,
                                        input logic [1:0] fa, input logic [1:0] fb);
        return RUNV | {4'b0000, fc, fd, fa, fb, 1'b0};
    endfunction

    task automatic clear_inputs();
        reset = 1'b0;
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
        ex_wrreg = '0; mem_wrreg = '0; wb_wrreg = '0;
        id_branch = 1'b0; id_jr = 1'b0; id_jump = 1'b0; id_taken = 1'b0;
        ex_regwr = 1'b0; ex_memrd = 1'b0; mem_regwr = 1'b0; mem_memrd = 1'b0;
        wb_regwr = 1'b0; irq = 1'b0;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            if (i < 2) begin
                reset = 1'b1;
                ex_memrd = 1'b1; ex_wrreg = 5'd5; id_rs = 5'd5; id_jump = 1'b1;
                mem_regwr = 1'b1; mem_wrreg = 5'd3; ex_rs = 5'd3; id_rt = 5'd3;
                irq = 1'b1;
            end
            sb.push_back(RUNV);
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL reset[%0d] got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 9; i++) begin
            begin_cycle();
            case (i)
                0: begin ex_memrd = 1'b1; ex_wrreg = 5'd5; id_rs = 5'd5; sb.push_back(STALLV); end
                1: begin ex_memrd = 1'b1; ex_wrreg = 5'd5; id_rs = 5'd5; sb.push_back(RUNV); end
                2: sb.push_back(RUNV);
                3: begin ex_memrd = 1'b1; ex_wrreg = 5'd12; id_rt = 5'd12; sb.push_back(STALLV); end
                4: sb.push_back(RUNV);
                5: begin ex_memrd = 1'b1; ex_wrreg = 5'd0; id_rs = 5'd0; sb.push_back(RUNV); end
                6: begin ex_regwr = 1'b1; ex_wrreg = 5'd4; id_rs = 5'd4; sb.push_back(RUNV); end
                7: begin ex_memrd = 1'b1; ex_wrreg = 5'd6; id_rs = 5'd7; sb.push_back(RUNV); end
                default: sb.push_back(RUNV);
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_branch_stall();
        for (int i = 0; i < 9; i++) begin
            begin_cycle();
            if (i <= 2) begin
                // Branch on an EX load; also a MEM load to rt that must not forward.
                id_branch = 1'b1; ex_memrd = 1'b1; ex_regwr = 1'b1; ex_wrreg = 5'd8;
                id_rt = 5'd8; mem_regwr = 1'b1; mem_memrd = 1'b1; mem_wrreg = 5'd8;
            end
            case (i)
                0, 1: sb.push_back(STALLV);
                2:    sb.push_back(RUNV);
                3:    sb.push_back(RUNV);
                4: begin id_branch = 1'b1; ex_regwr = 1'b1; ex_wrreg = 5'd4; id_rs = 5'd4;
                         sb.push_back(STALLV); end
                5:    sb.push_back(RUNV);
                6: begin id_jr = 1'b1; mem_regwr = 1'b1; mem_memrd = 1'b1; mem_wrreg = 5'd6;
                         id_rs = 5'd6; sb.push_back(STALLV); end
                7:    sb.push_back(RUNV);
                default: begin id_jr = 1'b1; ex_regwr = 1'b1; ex_wrreg = 5'd9; id_rt = 5'd9;
                         sb.push_back(RUNV); end
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL branch_stall[%0d] got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 6; i++) begin
            begin_cycle();
            case (i)
                0: begin mem_regwr = 1'b1; mem_wrreg = 5'd3; wb_regwr = 1'b1; wb_wrreg = 5'd3;
                         ex_rs = 5'd3; sb.push_back(fwd(1'b0, 1'b0, 2'b10, 2'b00)); end
                1: begin mem_regwr = 1'b1; mem_wrreg = 5'd0; wb_regwr = 1'b1; wb_wrreg = 5'd3;
                         ex_rs = 5'd3; sb.push_back(fwd(1'b0, 1'b0, 2'b01, 2'b00)); end
                2: begin mem_regwr = 1'b1; mem_wrreg = 5'd2; wb_regwr = 1'b1; wb_wrreg = 5'd7;
                         ex_rs = 5'd2; ex_rt = 5'd7; sb.push_back(fwd(1'b0, 1'b0, 2'b10, 2'b01)); end
                3: begin mem_regwr = 1'b1; mem_wrreg = 5'd9; id_rs = 5'd9; id_rt = 5'd9;
                         sb.push_back(fwd(1'b1, 1'b1, 2'b00, 2'b00)); end
                4: begin mem_regwr = 1'b1; mem_memrd = 1'b1; mem_wrreg = 5'd9; id_rs = 5'd9;
                         sb.push_back(RUNV); end
                default: begin wb_wrreg = 5'd4; ex_rs = 5'd4; mem_wrreg = 5'd5; id_rt = 5'd5;
                         sb.push_back(RUNV); end
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL forwarding[%0d] got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            begin_cycle();
            case (i)
                0: begin id_jump = 1'b1; sb.push_back(JUMPV); end
                1: sb.push_back(RUNV);
                2: begin id_branch = 1'b1; id_taken = 1'b1; sb.push_back(JUMPV); end
                3: begin id_branch = 1'b1; sb.push_back(RUNV); end
                4: begin id_jump = 1'b1; id_taken = 1'b1; ex_memrd = 1'b1; ex_wrreg = 5'd5;
                         id_rs = 5'd5; sb.push_back(STALLV); end
                default: sb.push_back(RUNV);
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL flush[%0d] got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_irq();
        for (int i = 0; i < 16; i++) begin
            begin_cycle();
            case (i)
                // plain edge
                0: begin irq = 1'b1; sb.push_back(RUNV); end
                1: begin irq = 1'b1; sb.push_back(TAKEV); end
                2: begin irq = 1'b1; sb.push_back(RUNV); end
                // edge during STALL1
                3: begin ex_memrd = 1'b1; ex_wrreg = 5'd5; id_rs = 5'd5; sb.push_back(STALLV); end
                4: begin irq = 1'b1; sb.push_back(RUNV); end
                5: begin irq = 1'b1; sb.push_back(TAKEV); end
                6: sb.push_back(RUNV);
                // pending held through a stall, new edge in the take cycle
                7: begin irq = 1'b1; ex_memrd = 1'b1; ex_wrreg = 5'd5; id_rs = 5'd5;
                         sb.push_back(STALLV); end
                8: sb.push_back(RUNV);
                9: begin irq = 1'b1; sb.push_back(TAKEV); end
                10: begin irq = 1'b1; sb.push_back(TAKEV); end
                11: sb.push_back(RUNV);
                // blocked by ifid_flush
                12: begin irq = 1'b1; sb.push_back(RUNV); end
                13: begin id_jump = 1'b1; sb.push_back(JUMPV); end
                14: sb.push_back(TAKEV);
                default: sb.push_back(RUNV);
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL irq[%0d] got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_in_stall();
        for (int i = 0; i < 9; i++) begin
            begin_cycle();
            case (i)
                0: begin irq = 1'b1; id_branch = 1'b1; ex_memrd = 1'b1; ex_wrreg = 5'd8;
                         id_rt = 5'd8; sb.push_back(STALLV); end
                1: begin reset = 1'b1; irq = 1'b1; id_branch = 1'b1; ex_memrd = 1'b1;
                         ex_wrreg = 5'd8; id_rt = 5'd8; sb.push_back(RUNV); end
                2: sb.push_back(RUNV);
                3: sb.push_back(RUNV);
                // STALL1 reset, then stored irq level must be 0 again
                4: begin ex_memrd = 1'b1; ex_wrreg = 5'd5; id_rs = 5'd5; sb.push_back(STALLV); end
                5: begin reset = 1'b1; irq = 1'b1; sb.push_back(RUNV); end
                6: begin irq = 1'b1; sb.push_back(RUNV); end
                7: begin irq = 1'b1; sb.push_back(TAKEV); end
                default: sb.push_back(RUNV);
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL reset_in_stall[%0d] got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_branch_stall();
        test_forwarding();
        test_flush();
        test_irq();
        test_reset_in_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
